// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states, defaults,
// and a counter-width helper.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud
  localparam int DEFAULT_DATA_WIDTH   = 8;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps on every bit
// boundary. The tick marks the last cycle of a bit period.
module uart_tx_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last && !i_clear;

  // Free-running count while enabled; held at zero while cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. One byte per valid/ready handshake, sent LSB first
// with one start and one stop bit. The line output is registered so it
// is glitch-free on the pin.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx_serial,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_idx;
  logic                  r_tx;
  logic                  r_done;

  logic w_tick;
  logic w_idle;
  logic w_handshake;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_handshake = i_valid && w_idle;

  assign o_ready     = w_idle;
  assign o_busy      = !w_idle;
  assign o_tx_serial = r_tx;
  assign o_done      = r_done;

  // Baud timer runs only while a frame is in flight, so every frame starts
  // with a full-length start bit.
  uart_tx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(w_idle),
    .o_tick (w_tick)
  );

  // Frame sequencer: state, shift register, bit index and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx      <= 1'b1;
          r_bit_idx <= '0;
          if (w_handshake) begin
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Expected line waveforms come from the
// 8N1 frame definition (start 0, data LSB first, stop 1, each N cycles).
module tb_uart_tx;

  localparam int N  = 4;
  localparam int N2 = 217;
  localparam int FRAME  = 10 * N;
  localparam int FRAME2 = 10 * N2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy, done;
  logic [7:0] data2 = 8'h00;
  logic       valid2 = 1'b0;
  logic       ready2, tx2, busy2, done2;

  int checks = 0;
  int errors = 0;

  logic q_tx[$];
  logic q_done[$];
  logic q_busy[$];
  logic q_ready[$];
  logic q_tx2[$];
  logic q_done2[$];
  logic [7:0] dec_bytes[$];
  int         dec_starts[$];

  uart_tx #(.CLKS_PER_BIT(N), .DATA_WIDTH(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx_serial(tx), .o_busy(busy), .o_done(done)
  );

  uart_tx #(.CLKS_PER_BIT(N2), .DATA_WIDTH(8)) u_dut217 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_tx_serial(tx2), .o_busy(busy2), .o_done(done2)
  );

  always #5 clk = ~clk;

  // Reference line level idx cycles after the handshake edge (idx 0 = first
  // cycle of the start bit); anything past the stop bit is idle high.
  function automatic logic exp_line(input logic [7:0] b, input int idx, input int n);
    int p;
    if (idx < 0) return 1'b1;
    p = idx / n;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  // Records num samples on consecutive falling edges, starting with the current one.
  task automatic capture(input int num);
    q_tx.delete(); q_done.delete(); q_busy.delete(); q_ready.delete();
    q_tx2.delete(); q_done2.delete();
    for (int i = 0; i < num; i++) begin
      if (i != 0) @(negedge clk);
      q_tx.push_back(tx);      q_done.push_back(done);
      q_busy.push_back(busy);  q_ready.push_back(ready);
      q_tx2.push_back(tx2);    q_done2.push_back(done2);
    end
  endtask

  // Mid-bit sampling receiver over a recorded line.
  task automatic decode(input bit big);
    int n, sz, i, pos;
    logic [7:0] b;
    logic v, stop;
    n  = big ? N2 : N;
    sz = big ? q_tx2.size() : q_tx.size();
    dec_bytes.delete(); dec_starts.delete();
    i = 0;
    while (i < sz) begin
      v = big ? q_tx2[i] : q_tx[i];
      if (v === 1'b0 && (i + 10 * n) <= sz) begin
        for (int k = 0; k < 8; k++) begin
          pos = i + n / 2 + (k + 1) * n;
          b[k] = big ? q_tx2[pos] : q_tx[pos];
        end
        pos  = i + n / 2 + 9 * n;
        stop = big ? q_tx2[pos] : q_tx[pos];
        if (stop === 1'b1) begin
          dec_bytes.push_back(b);
          dec_starts.push_back(i);
          i = i + 10 * n;
        end else begin
          i++;
        end
      end else begin
        i++;
      end
    end
  endtask

  // Waits (bounded) for ready, offers b for one cycle; returns on the falling
  // edge right after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit big, output bit ok);
    int t;
    ok = 1'b0;
    @(negedge clk);
    t = 0;
    while (((big ? ready2 : ready) !== 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) return;
    if (big) begin data2 = b; valid2 = 1'b1; end
    else     begin data  = b; valid  = 1'b1; end
    @(negedge clk);
    valid  = 1'b0;
    valid2 = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    #23;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_idle_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    logic e_tx, e_done, e_busy;
    send_byte(8'h55, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_handshake timeout"); end
    capture(FRAME + 4);
    for (int i = 0; i < FRAME + 4; i++) begin
      e_tx   = exp_line(8'h55, i, N);
      e_done = (i == FRAME);
      e_busy = (i < FRAME);
      checks++; if (q_tx[i] !== e_tx)     begin errors++; $display("FAIL single_tx cyc %0d got %b want %b", i, q_tx[i], e_tx); end
      checks++; if (q_done[i] !== e_done) begin errors++; $display("FAIL single_done cyc %0d got %b want %b", i, q_done[i], e_done); end
      checks++; if (q_busy[i] !== e_busy) begin errors++; $display("FAIL single_busy cyc %0d got %b want %b", i, q_busy[i], e_busy); end
      checks++; if (q_ready[i] !== !e_busy) begin errors++; $display("FAIL single_ready cyc %0d got %b want %b", i, q_ready[i], !e_busy); end
    end
  endtask

  task automatic test_back_to_back();
    int t, ndone;
    logic e_tx;
    @(negedge clk);
    t = 0;
    while (ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    checks++; if (t >= 100) begin errors++; $display("FAIL b2b_ready timeout"); end
    data = 8'hA5; valid = 1'b1;
    @(negedge clk);
    data = 8'h3C;
    fork
      capture(100);
      begin repeat (FRAME + 1) @(negedge clk); valid = 1'b0; end
    join
    for (int i = 0; i < 100; i++) begin
      e_tx = (i <= FRAME) ? exp_line(8'hA5, i, N) : exp_line(8'h3C, i - (FRAME + 1), N);
      checks++; if (q_tx[i] !== e_tx) begin errors++; $display("FAIL b2b_tx cyc %0d got %b want %b", i, q_tx[i], e_tx); end
    end
    ndone = 0;
    foreach (q_done[i]) if (q_done[i] === 1'b1) ndone++;
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
    decode(1'b0);
    checks++; if (dec_bytes.size() != 2) begin errors++; $display("FAIL b2b_frames got %0d want 2", dec_bytes.size()); end
    else begin
      checks++; if (dec_bytes[0] !== 8'hA5) begin errors++; $display("FAIL b2b_byte0 got %h want a5", dec_bytes[0]); end
      checks++; if (dec_bytes[1] !== 8'h3C) begin errors++; $display("FAIL b2b_byte1 got %h want 3c", dec_bytes[1]); end
      checks++; if (dec_starts[1] - dec_starts[0] != FRAME + 1) begin
        errors++; $display("FAIL b2b_period got %0d want %0d", dec_starts[1] - dec_starts[0], FRAME + 1);
      end
    end
  endtask

  task automatic test_ignored();
    bit ok;
    int ndone, nboth;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    send_byte(b, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignored_handshake timeout"); end
    fork
      capture(60);
      begin
        repeat (38) begin
          @(negedge clk);
          valid = ($urandom_range(0, 1) == 1);
          data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        valid = 1'b0;
      end
    join
    ndone = 0; nboth = 0;
    for (int i = 0; i < 60; i++) begin
      checks++; if (q_tx[i] !== exp_line(b, i, N)) begin
        errors++; $display("FAIL ignored_tx cyc %0d got %b want %b", i, q_tx[i], exp_line(b, i, N));
      end
      if (q_done[i] === 1'b1) ndone++;
      if (q_busy[i] === 1'b1 && q_ready[i] === 1'b1) nboth++;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
    checks++; if (nboth != 0) begin errors++; $display("FAIL ignored_busy_ready_overlap got %0d want 0", nboth); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int ndone;
    send_byte(8'hFF, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_handshake timeout"); end
    repeat (17) @(negedge clk);           // inside data bit 3
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL abort_ff_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_ff_busy got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    capture(FRAME);
    ndone = 0;
    foreach (q_done[i]) if (q_done[i] === 1'b1) ndone++;
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done_count got %0d want 0", ndone); end
    send_byte(8'h00, 1'b0, ok);
    repeat (13) @(negedge clk);           // inside data bit 2, line low
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL abort_00_pre got %b want 0", tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_00_tx got %b want 1", tx); end
    // release reset together with valid: accepted on the first edge with rst low
    @(negedge clk);
    rst = 1'b0; valid = 1'b1; data = 8'h00;
    @(negedge clk);
    valid = 1'b0;
    capture(FRAME + 2);
    for (int i = 0; i < FRAME + 2; i++) begin
      checks++; if (q_tx[i] !== exp_line(8'h00, i, N)) begin
        errors++; $display("FAIL abort_clean_tx cyc %0d got %b want %b", i, q_tx[i], exp_line(8'h00, i, N));
      end
      checks++; if (q_done[i] !== (i == FRAME)) begin
        errors++; $display("FAIL abort_clean_done cyc %0d got %b want %b", i, q_done[i], (i == FRAME));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    for (int f = 0; f < 6; f++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_byte(b, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL random_handshake frame %0d timeout", f); end
      capture(FRAME + 1);
      for (int i = 0; i <= FRAME; i++) begin
        checks++; if (q_tx[i] !== exp_line(b, i, N)) begin
          errors++; $display("FAIL random_tx byte %h cyc %0d got %b want %b", b, i, q_tx[i], exp_line(b, i, N));
        end
      end
      checks++; if (q_done[FRAME] !== 1'b1) begin errors++; $display("FAIL random_done byte %h got %b want 1", b, q_done[FRAME]); end
    end
  endtask

  task automatic test_baud217();
    bit ok;
    int fall, rise;
    send_byte(8'h41, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b217_handshake timeout"); end
    capture(FRAME2 + 3);
    fall = -1; rise = -1;
    for (int i = 0; i < q_tx2.size(); i++) begin
      if (fall < 0 && q_tx2[i] === 1'b0) fall = i;
      else if (fall >= 0 && rise < 0 && q_tx2[i] === 1'b1) rise = i;
    end
    checks++; if (rise - fall != N2) begin errors++; $display("FAIL b217_bit_period got %0d want %0d", rise - fall, N2); end
    checks++; if (q_done2[FRAME2] !== 1'b1) begin errors++; $display("FAIL b217_done got %b want 1", q_done2[FRAME2]); end
    decode(1'b1);
    checks++; if (dec_bytes.size() != 1) begin errors++; $display("FAIL b217_frames got %0d want 1", dec_bytes.size()); end
    else begin
      checks++; if (dec_bytes[0] !== 8'h41) begin errors++; $display("FAIL b217_byte got %h want 41", dec_bytes[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_reset_midframe();
    test_random();
    test_baud217();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
